// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state type for the memory responder
package mem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int WAIT_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side memory request/response bundle
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          mem_ready;
  logic          busy;
  logic          req_err;
  logic          addr_err;
  modport master (output mem_read, mem_write, address, data_in,
                  input data_out, mem_ready, busy, req_err, addr_err);
  modport slave (input mem_read, mem_write, address, data_in,
                 output data_out, mem_ready, busy, req_err, addr_err);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port word storage, registered read, out-of-range accesses dropped/read as zero
module mem_array #(
  parameter int DW = 32,
  parameter int AW = 9,
  parameter int DEPTH = 512
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic in_range;
  assign in_range = {1'b0, addr} < (AW+1)'(DEPTH);
  // storage is deliberately not reset
  always_ff @(posedge clock)
    if (we && in_range) mem[addr] <= wdata;
  // read register holds until the next read
  always_ff @(posedge clock or negedge clear)
    if (!clear) rdata <= '0;
    else if (re) rdata <= in_range ? mem[addr] : '0;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder for the MAR/MDR interface; MEM_ADDR_CHECK_EN enables addr_err
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WAIT_STATES = 2
) (
  input logic clock,
  input logic clear,
  mem_responder_if.slave bus
);
  state_t                  state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic                    armed;
  logic                    op_wr;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q;
  logic                    access;
  assign access = state == ACCESS;
`ifdef MEM_ADDR_CHECK_EN
  logic oor;
  assign oor = !({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
`endif
  mem_array #(.DW(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_array (
    .clock(clock),
    .clear(clear),
    .we(access && op_wr),
    .re(access && !op_wr),
    .addr(addr_q),
    .wdata(data_q),
    .rdata(bus.data_out)
  );
  // request sequencing: sample, count wait states, access, then one-shot completion
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      state <= IDLE;
      cnt <= '0;
      armed <= 1'b1;
      op_wr <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      bus.busy <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.req_err <= 1'b0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.mem_ready <= 1'b0;
      bus.req_err <= 1'b0;
      bus.addr_err <= 1'b0;
      if (!bus.mem_read && !bus.mem_write) armed <= 1'b1;
      case (state)
        IDLE:
          if (armed && (bus.mem_read ^ bus.mem_write)) begin
            op_wr <= bus.mem_write;
            addr_q <= bus.address;
            data_q <= bus.data_in;
            cnt <= WAIT_CNT_W'(WAIT_STATES);
            bus.busy <= 1'b1;
            state <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end else if (armed && bus.mem_read && bus.mem_write) begin
            bus.req_err <= 1'b1;
            armed <= 1'b0;
          end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == WAIT_CNT_W'(1)) state <= ACCESS;
        end
        ACCESS: begin
          bus.mem_ready <= 1'b1;
          bus.busy <= 1'b0;
          armed <= 1'b0;
`ifdef MEM_ADDR_CHECK_EN
          bus.addr_err <= oor;
`endif
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of wait-state timing, rearm, req_err, reset abort and range handling
module tb_mem_responder;
  logic clock = 0;
  logic clear = 1;
  int checks = 0;
  int errors = 0;
  localparam logic EXP_AERR =
`ifdef MEM_ADDR_CHECK_EN
    1'b1;
`else
    1'b0;
`endif
  logic        rd [2];
  logic        wr [2];
  logic [8:0]  ad [2];
  logic [31:0] di [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        rerr [2];
  logic        aerr [2];
  logic [31:0] dout [2];
  mem_responder_if ia ();
  mem_responder_if ib ();
  assign ia.mem_read = rd[0];
  assign ia.mem_write = wr[0];
  assign ia.address = ad[0];
  assign ia.data_in = di[0];
  assign ib.mem_read = rd[1];
  assign ib.mem_write = wr[1];
  assign ib.address = ad[1];
  assign ib.data_in = di[1];
  assign rdy[0] = ia.mem_ready;
  assign bsy[0] = ia.busy;
  assign rerr[0] = ia.req_err;
  assign aerr[0] = ia.addr_err;
  assign dout[0] = ia.data_out;
  assign rdy[1] = ib.mem_ready;
  assign bsy[1] = ib.busy;
  assign rerr[1] = ib.req_err;
  assign aerr[1] = ib.addr_err;
  assign dout[1] = ib.data_out;
  mem_responder #(.DEPTH(384), .WAIT_STATES(2)) dut_a (.clock(clock), .clear(clear), .bus(ia.slave));
  mem_responder #(.DEPTH(512), .WAIT_STATES(0)) dut_b (.clock(clock), .clear(clear), .bus(ib.slave));
  always #5 clock = ~clock;

  task automatic xact(input int s, input logic w, input logic [8:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] dout_o, output logic aerr_o);
    rd[s] = 0; wr[s] = 0;
    @(posedge clock); #1;
    rd[s] = !w; wr[s] = w; ad[s] = a; di[s] = d;
    lat = -1; dout_o = '0; aerr_o = 0;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clock); #1;
      if (rdy[s]) begin
        lat = n; dout_o = dout[s]; aerr_o = aerr[s];
        break;
      end
    end
    rd[s] = 0; wr[s] = 0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin rd[s] = 0; wr[s] = 0; ad[s] = '0; di[s] = '0; end
    #2 clear = 0;
    @(posedge clock); #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({dout[s], rdy[s], bsy[s], rerr[s], aerr[s]} !== 36'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %h exp 0", s, {dout[s], rdy[s], bsy[s], rerr[s], aerr[s]});
      end
    end
    clear = 1;
    @(posedge clock); #1;
    checks++;
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", bsy[0]); end
  endtask

  task automatic test_write_read();
    logic [4:0] eb = 5'b00111;
    logic [4:0] er = 5'b01000;
    int lat; logic [31:0] d; logic ae;
    rd[0] = 0; wr[0] = 0;
    @(posedge clock); #1;
    wr[0] = 1; ad[0] = 9'h005; di[0] = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      wr[0] = 0;
      checks++;
      if (bsy[0] !== eb[i]) begin errors++; $display("FAIL wr_busy_edge%0d got %b exp %b", i, bsy[0], eb[i]); end
      checks++;
      if (rdy[0] !== er[i]) begin errors++; $display("FAIL wr_ready_edge%0d got %b exp %b", i, rdy[0], er[i]); end
    end
    xact(0, 0, 9'h005, 0, lat, d, ae);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", d); end
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] d; logic ae; int pulses = 0;
    xact(1, 1, 9'h000, 32'h0, lat, d, ae);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zw_wr_latency got %0d exp 1", lat); end
    @(posedge clock); #1;
    rd[1] = 1; ad[1] = 9'h000;
    @(posedge clock); #1;
    checks++;
    if (bsy[1] !== 1'b1 || rdy[1] !== 1'b0) begin errors++; $display("FAIL zw_edge0 got busy %b ready %b exp 1 0", bsy[1], rdy[1]); end
    @(posedge clock); #1;
    checks++;
    if (rdy[1] !== 1'b1 || dout[1] !== 32'h0) begin errors++; $display("FAIL zw_read got ready %b data %h exp 1 0", rdy[1], dout[1]); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (rdy[1]) pulses++;
    end
    rd[1] = 0;
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL zw_held_retrigger got %0d exp 0", pulses); end
    xact(1, 1, 9'h001, 32'h5A5A5A5A, lat, d, ae);
    xact(1, 0, 9'h001, 0, lat, d, ae);
    checks++;
    if (lat !== 1 || d !== 32'h5A5A5A5A) begin errors++; $display("FAIL zw_readback got lat %0d data %h exp 1 5a5a5a5a", lat, d); end
  endtask

  task automatic test_req_err();
    int lat; logic [31:0] d; logic ae; int errs = 0; int rdys = 0; int bsys = 0;
    rd[0] = 0; wr[0] = 0;
    @(posedge clock); #1;
    rd[0] = 1; wr[0] = 1; ad[0] = 9'h005; di[0] = 32'h0;
    @(posedge clock); #1;
    checks++;
    if (rerr[0] !== 1'b1) begin errors++; $display("FAIL req_err_pulse got %b exp 1", rerr[0]); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (rerr[0]) errs++;
      if (rdy[0]) rdys++;
      if (bsy[0]) bsys++;
    end
    checks++;
    if (errs !== 0 || rdys !== 0 || bsys !== 0) begin errors++; $display("FAIL req_err_quiet got err %0d ready %0d busy %0d exp 0 0 0", errs, rdys, bsys); end
    checks++;
    if (dout[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL req_err_dout got %h exp deadbeef", dout[0]); end
    rd[0] = 0; wr[0] = 0;
    xact(0, 0, 9'h005, 0, lat, d, ae);
    checks++;
    if (lat !== 3 || d !== 32'hDEADBEEF) begin errors++; $display("FAIL req_err_recover got lat %0d data %h exp 3 deadbeef", lat, d); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic ae;
    xact(0, 1, 9'h010, 32'h12345678, lat, d, ae);
    @(posedge clock); #1;
    wr[0] = 1; ad[0] = 9'h010; di[0] = 32'hFFFFFFFF;
    @(posedge clock); #1;
    checks++;
    if (bsy[0] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", bsy[0]); end
    @(posedge clock); #1;
    clear = 0;
    #1;
    checks++;
    if ({dout[0], rdy[0], bsy[0], rerr[0], aerr[0]} !== 36'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h exp 0", {dout[0], rdy[0], bsy[0], rerr[0], aerr[0]});
    end
    wr[0] = 0;
    @(posedge clock); #1;
    clear = 1;
    xact(0, 0, 9'h010, 0, lat, d, ae);
    checks++;
    if (lat !== 3 || d !== 32'h12345678) begin errors++; $display("FAIL mid_no_write got lat %0d data %h exp 3 12345678", lat, d); end
  endtask

  task automatic test_addr_range();
    int lat; logic [31:0] d; logic ae;
    xact(0, 1, 9'h1F0, 32'hAAAA5555, lat, d, ae);
    checks++;
    if (lat !== 3 || ae !== EXP_AERR) begin errors++; $display("FAIL oor_write got lat %0d aerr %b exp 3 %b", lat, ae, EXP_AERR); end
    xact(0, 0, 9'h1F0, 0, lat, d, ae);
    checks++;
    if (lat !== 3 || d !== 32'h0 || ae !== EXP_AERR) begin errors++; $display("FAIL oor_read got lat %0d data %h aerr %b exp 3 0 %b", lat, d, ae, EXP_AERR); end
    xact(0, 1, 9'h17F, 32'h77777777, lat, d, ae);
    xact(0, 0, 9'h17F, 0, lat, d, ae);
    checks++;
    if (d !== 32'h77777777 || ae !== 1'b0) begin errors++; $display("FAIL last_word got data %h aerr %b exp 77777777 0", d, ae); end
  endtask

  task automatic test_latch();
    int lat = -1; logic [31:0] d; logic ae;
    xact(0, 1, 9'h021, 32'h11111111, lat, d, ae);
    @(posedge clock); #1;
    wr[0] = 1; ad[0] = 9'h020; di[0] = 32'hCAFEF00D;
    @(posedge clock); #1;
    ad[0] = 9'h021; di[0] = 32'h0BADBEEF;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (rdy[0]) begin lat = n; break; end
    end
    wr[0] = 0;
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL latch_latency got %0d exp 3", lat); end
    xact(0, 0, 9'h020, 0, lat, d, ae);
    checks++;
    if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL latch_addr20 got %h exp cafef00d", d); end
    xact(0, 0, 9'h021, 0, lat, d, ae);
    checks++;
    if (d !== 32'h11111111) begin errors++; $display("FAIL latch_addr21 got %h exp 11111111", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_req_err();
    test_reset_mid();
    test_addr_range();
    test_latch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
